// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stall > redirect > load-use, with multi-cycle IF/ID flush.
// Stall/clear outputs are combinational from registered state and current inputs; no backpressure of its own.
module hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic redirect_acc;
    logic flushing;
    logic rs_hit;
    logic load_use;

    assign mem_stall    = mem_req & ~mem_ready;
    assign redirect_acc = ex_redirect & ~mem_stall;
    assign flushing     = (state_q == FLUSH) & ~mem_stall & ~ex_redirect;
    assign rs_hit       = (id_uses_rs1 & (id_rs1 == ex_rd)) |
                          (id_uses_rs2 & (id_rs2 == ex_rd));
    // The ID instruction is being cleared during FLUSH, so a load-use match there is moot.
    assign load_use     = ex_mem_read & (ex_rd != 5'd0) & rs_hit &
                          ~mem_stall & ~ex_redirect & (state_q != FLUSH);

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_clr    = 1'b0;
        idex_clr    = 1'b0;
        if (!rst_n) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (mem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (redirect_acc) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (flushing) begin
            ifid_clr = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_clr   = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (mem_stall) begin
            // A stall inside FLUSH freezes the flush countdown rather than leaving FLUSH.
            if (state_q != FLUSH) begin
                state_d = MEM_WAIT;
            end
        end else if (redirect_acc) begin
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                fcnt_d  = FLUSH_LOAD;
            end else begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end
        end else if (state_q == FLUSH) begin
            fcnt_d = fcnt_q - 2'd1;
            if (fcnt_q <= 2'd1) begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int FC    = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic             pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: remaining ifid-clear cycles after a redirect, a "waiting on memory" flag, plain int counters.
    int m_flush_rem;
    bit m_mem_wait;
    int m_stall_cnt;
    int m_flush_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_load_use();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr}
    function automatic logic [5:0] exp_ctl();
        if (!rst_n)                        return 6'b000011;
        if (mem_req && !mem_ready)         return 6'b111100;
        if (ex_redirect)                   return 6'b000011;
        if (m_flush_rem > 0)               return 6'b000010;
        if (is_load_use())                 return 6'b110001;
        return 6'b000000;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_flush_rem > 0) return 2'b10;
        if (m_mem_wait)      return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_flush_rem = 0;
        m_mem_wait  = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic model_edge();
        logic [5:0] c;
        if (!rst_n) begin
            model_reset();
        end else begin
            c = exp_ctl();
            if (c[5]) m_stall_cnt = (m_stall_cnt < SAT) ? m_stall_cnt + 1 : SAT;
            if (mem_req && !mem_ready) begin
                m_mem_wait = (m_flush_rem == 0);
            end else if (ex_redirect) begin
                m_flush_rem = FC - 1;
                m_flush_cnt = (m_flush_cnt < SAT) ? m_flush_cnt + 1 : SAT;
                m_mem_wait  = 1'b0;
            end else begin
                if (m_flush_rem > 0) m_flush_rem--;
                m_mem_wait = 1'b0;
            end
        end
    endtask

    task automatic check_now();
        chk("ctl", {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr}, exp_ctl());
        chk("state", state, exp_state());
        chk("stall_count", stall_count, m_stall_cnt);
        chk("flush_count", flush_count, m_flush_cnt);
    endtask

    // Entered and left at posedge+1; checks at the falling edge.
    task automatic step();
        #4 check_now();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #4 check_now();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #3 check_now();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load-use on rs2, then the same pattern with ex_rd=0.
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        step();
        chk("lu_stall_count", stall_count, 1);
        ex_rd = 5'd0; id_rs2 = 5'd0;
        step();
        chk("lu_rd0_count", stall_count, 1);
        set_idle();
        step();

        // Three-cycle memory stall.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) begin
            step();
            chk("mw_state", state, 2'b01);
        end
        mem_ready = 1'b1;
        step();
        chk("mw_exit_state", state, 2'b00);
        chk("mw_stall_count", stall_count, 3);
        set_idle();

        // Redirect pulse with a three-cycle flush.
        do_reset();
        ex_redirect = 1'b1;
        step();
        chk("rd_flush_count", flush_count, 1);
        chk("rd_state", state, 2'b10);
        ex_redirect = 1'b0;
        repeat (3) step();
        chk("rd_end_state", state, 2'b00);

        // Everything at once: memory stall wins.
        do_reset();
        ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        chk("all_flush_count", flush_count, 0);
        chk("all_state", state, 2'b01);
        set_idle();
        step();

        // Counter saturation.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (20) step();
        chk("sat_stall_count", stall_count, 15);

        // Asynchronous reset during MEM_WAIT.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_stall_count", stall_count, 0);
        chk("arst_ctl", {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr}, 6'b000011);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_idle();
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            mem_req     = ($urandom_range(0, 9) < 3);
            mem_ready   = $urandom_range(0, 1) != 0;
            ex_redirect = ($urandom_range(0, 9) < 2);
            ex_mem_read = $urandom_range(0, 1) != 0;
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1) != 0;
            id_uses_rs2 = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 99) == 0) do_reset();
            else                            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
